nibble_red_seq: RTL and testbench
=================================

# nibble_red_seq

Multi-cycle nibble-pair reduction sequencer that feeds the 5-bit carry-lookahead adder stage. It splits two 16-bit operands into four nibble pairs and steps one pair per cycle through a single `CLA_5bit` instance. Each pair's sum is extended and accumulated into a 16-bit result. It sits in the execute-stage reduction path and reports completion through a start/busy/done handshake.

## Interface
- No parameters. Widths are fixed: 16-bit operands, 4 nibble pairs, one `CLA_5bit` instance.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `start`: input, 1 bit. Request a reduction. Sampled only in IDLE.
- `signed_mode`: input, 1 bit.
  - 1: nibbles are signed 4-bit values.
  - 0: nibbles are unsigned.
  - Latched with `start`.
- `A`: input, 16 bits. Operand A. Latched when `start` is accepted.
- `B`: input, 16 bits. Operand B. Latched when `start` is accepted.
- `busy`: output, 1 bit. High while state ≠ IDLE.
- `done`: output, 1 bit. One-cycle pulse; `result` is final while it is high.
- `result`: output, 16 bits. Two's-complement reduction result. Holds until the next completion.

## Operation
- Function:
  - result = Σ(k=0..3) ( ext(A[4k+3:4k]) + ext(B[4k+3:4k]) ).
  - Signed mode: ext is sign-extension; unsigned mode: ext is zero-extension.
- Per-pair add uses the `CLA_5bit` instance.
  - Inputs: each nibble extended to 5 bits.
  - Signed mode: bit 4 = nibble bit 3. Take Sum[4:0] as a 5-bit signed value and sign-extend it to 16 bits. Range −16..14, so Sum[5] is ignored.
  - Unsigned mode: bit 4 = 0. Take Sum[5:0], zero-extended to 16 bits. Range 0..30.
- Accumulator: 16-bit register, two's-complement add.
  - Final ranges: unsigned 0..120, signed −64..56.
  - Overflow is impossible; no saturation logic.
- Operand registers `a_q`, `b_q`, `mode_q` are captured on start acceptance. Inputs `A`, `B` and `signed_mode` are ignored afterwards.
- Pair index `cnt` (2 bits) selects nibble k = cnt. Pair 0 is the LSB nibble.
- State machine:
  - IDLE: if `start`, latch operands, acc←0, cnt←0, go to RUN. Otherwise stay.
  - RUN: acc←acc+pairsum(cnt), cnt←cnt+1. When cnt==3, go to DONE and load result←acc+pairsum(3). Otherwise stay.
  - DONE: `done`=1 for this cycle, go to IDLE unconditionally. `start` in DONE is ignored.
- `start` while busy is ignored: no restart, no queueing.
- `cnt` wraps 3→0 only on exit from RUN. It is never observable in IDLE.

## Timing
- Reset (async assert, any state):
  - state=IDLE, `busy`=0, `done`=0, `result`=16'h0000, acc=0, cnt=0.
  - Takes effect immediately, without a clock edge.
- Reset deassertion: the first edge with `rst_n`=1 can accept `start`.
- Reset mid-operation: the operation is aborted, no `done` pulse, `result` reads 0.
- Latency, with `start` sampled high at edge E0:
  - Edges E1..E4 process pairs 0..3.
  - After E4: state DONE, `done`=1, `result` valid.
  - After E5: IDLE, `busy`=0.
  - Start-to-done is 4 cycles; `busy` is high for 5 cycles.
- `done` is registered: high for exactly one cycle, coincident with the first cycle in which the new `result` is visible.
- If `start` is held high continuously, a new operation is accepted at the first IDLE edge. The issue period is 6 cycles.
- `result` changes only on the RUN→DONE edge or on reset.

## Test plan
- Unsigned max: `signed_mode`=0, A=16'hFFFF, B=16'hFFFF, `start` pulse.
  - Required: `done` high exactly 4 cycles after the `start` edge, `result`=16'h0078 (120).
  - Required: `busy` high for 5 cycles.
- Signed min: `signed_mode`=1, A=16'h8888, B=16'h8888.
  - Required: `result`=16'hFFC0 (−64).
- Mixed values with A=16'hF7F7, B=16'h0101:
  - Signed mode: `result`=16'h000E (pairs 8, −1, 8, −1).
  - Unsigned mode: `result`=16'h002E (pairs 8, 15, 8, 15).
- Ignore while busy:
  - Stimulus: start A=16'h1234, B=0 unsigned. Pulse `start` again with A=16'hFFFF one and two cycles later. Change `A`/`B` every cycle during RUN.
  - Required: a single `done`, `result`=16'h000A.
  - Required: the second request is not executed.
- Reset mid-run:
  - Stimulus: start A=16'hFFFF, B=16'hFFFF. Assert `rst_n`=0 asynchronously 2 cycles after `start`, between clock edges.
  - Required: `busy`, `done` and `result` go to 0 immediately.
  - Required: no `done` pulse after release. A fresh start with A=16'h0001, B=16'h0001 unsigned yields `result`=16'h0002.
- Back-to-back: hold `start`=1 continuously with A=16'h1111, B=16'h1111, unsigned.
  - Required: `done` pulses every 6 cycles, `result`=16'h0008 each time.
  - Required: `done` never fires in two consecutive cycles.

Source files
------------

// File: rtl/nibble_red_seq.sv
// Nibble-pair reduction sequencer: one nibble pair per cycle through a
// 5-bit CLA, accumulated into a 16-bit two's-complement result.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request (sampled only when idle)
//   signed_mode       1: signed nibbles, 0: unsigned (latched with start)
//   A, B              16-bit operands (latched with start)
//   busy              high while not idle
//   done              one-cycle pulse when result is final
//   result            reduction result, held until next completion

module CLA_5bit (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [5:0] sum
);

  logic [4:0] g;
  logic [4:0] p;
  logic [5:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead: every carry is a function of g, p and cin only.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign c[5] = g[4] | (p[4] & g[3])
              | (p[4] & p[3] & g[2])
              | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0])
              | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = {c[5], p ^ c[4:0]};

endmodule

module nibble_red_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_mode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q;
  state_t      state_n;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        mode_q;
  logic [15:0] acc_q;
  logic [1:0]  cnt_q;
  logic [15:0] result_q;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  a_ext;
  logic [4:0]  b_ext;
  logic [5:0]  sum;
  logic [15:0] pair;

  assign a_nib = a_q[{cnt_q, 2'b00} +: 4];
  assign b_nib = b_q[{cnt_q, 2'b00} +: 4];
  assign a_ext = {mode_q & a_nib[3], a_nib};
  assign b_ext = {mode_q & b_nib[3], b_nib};

  CLA_5bit u_cla (
    .a   (a_ext),
    .b   (b_ext),
    .cin (1'b0),
    .sum (sum)
  );

  // Signed pair sums fit in 5 bits (-16..14); sum[5] is a stale carry there.
  assign pair = mode_q ? {{11{sum[4]}}, sum[4:0]}
                       : {10'd0, sum};

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_n = S_RUN;
      S_RUN:  if (cnt_q == 2'd3) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            mode_q <= signed_mode;
            acc_q  <= '0;
            cnt_q  <= '0;
          end
        end
        S_RUN: begin
          acc_q <= acc_q + pair;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) result_q <= acc_q + pair;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_nibble_red_seq.sv
// Scoreboard bench for nibble_red_seq: expected results queued at issue,
// popped and compared on each done pulse.

module tb_nibble_red_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] result;

  logic [15:0] exp_q[$];
  int total;
  int bad;

  nibble_red_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    A = '0;
    B = '0;
    #3;
    total++;
    if ({busy, done, result} !== 18'd0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b result=%h want 0 0 0000",
               busy, done, result);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic [15:0] exp,
                        input string name);
    int lat;
    logic [15:0] e;
    bit seen;
    A = a;
    B = b;
    signed_mode = m;
    start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    seen = 0;
    while (!seen && lat < 12) begin
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout got no done want done", name);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (result !== e) begin
        bad++;
        $display("FAIL %s_result got %h want %h", name, result, e);
      end
      total++;
      if (lat !== 5) begin
        bad++;
        $display("FAIL %s_latency got %0d want 5", name, lat);
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle got busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_unsigned_max;
    int busy_cnt;
    int done_at;
    logic [15:0] e;
    A = 16'hFFFF;
    B = 16'hFFFF;
    signed_mode = 1'b0;
    start = 1'b1;
    exp_q.push_back(16'h0078);
    busy_cnt = 0;
    done_at = -1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_at = i;
        e = exp_q.pop_front();
        total++;
        if (result !== e) begin
          bad++;
          $display("FAIL umax_result got %h want %h", result, e);
        end
      end
    end
    total++;
    if (done_at !== 5) begin
      bad++;
      $display("FAIL umax_done_cycle got %0d want 5", done_at);
    end
    total++;
    if (busy_cnt !== 5) begin
      bad++;
      $display("FAIL umax_busy_cycles got %0d want 5", busy_cnt);
    end
  endtask

  task automatic test_signed;
    run_op(16'h8888, 16'h8888, 1'b1, 16'hFFC0, "smin");
    run_op(16'hF7F7, 16'h0101, 1'b1, 16'h000E, "mix_s");
    run_op(16'hF7F7, 16'h0101, 1'b0, 16'h002E, "mix_u");
  endtask

  task automatic test_ignore_busy;
    int dones;
    logic [15:0] e;
    A = 16'h1234;
    B = 16'h0000;
    signed_mode = 1'b0;
    start = 1'b1;
    exp_q.push_back(16'h000A);
    dones = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      start = (i <= 2);
      A = (i <= 2) ? 16'hFFFF : 16'($urandom);
      B = 16'($urandom);
      signed_mode = 1'($urandom);
      if (done === 1'b1) begin
        dones++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ignore_extra_done got result=%h want none", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e) begin
            bad++;
            $display("FAIL ignore_result got %h want %h", result, e);
          end
        end
      end
    end
    start = 1'b0;
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL ignore_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    A = 16'hFFFF;
    B = 16'hFFFF;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, result} !== 18'd0) begin
      bad++;
      $display("FAIL midrst_clear got busy=%b done=%b result=%h want 0 0 0000",
               busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones !== 0 || result !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_no_done got dones=%0d result=%h want 0 0000",
               dones, result);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, "post_rst");
  endtask

  task automatic test_back_to_back;
    int dones;
    logic want;
    logic [15:0] e;
    A = 16'h1111;
    B = 16'h1111;
    signed_mode = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      want = (k % 6 == 5);
      total++;
      if (done !== want) begin
        bad++;
        $display("FAIL b2b_done_k%0d got %b want %b", k, done, want);
      end
      if (done === 1'b1) begin
        dones++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra got result=%h want none", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e) begin
            bad++;
            $display("FAIL b2b_result got %h want %h", result, e);
          end
        end
      end
      if (k % 6 == 0) exp_q.push_back(16'h0008);
      start = (k < 29);
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (dones !== 5 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got dones=%0d left=%0d want 5 0",
               dones, exp_q.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_unsigned_max();
    @(negedge clk);
    test_signed();
    test_ignore_busy();
    test_reset_mid();
    @(negedge clk);
    test_back_to_back();
    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
